// File: rtl/flash_prog_ctrl.sv
// flash_prog_ctrl: EN25F80 write-side SPI controller (WREN, page program / 4KB sector erase, RDSR poll until WIP clears)
//  clkMain, rst                          system clock, synchronous active-high reset
//  devEnable_i, erase_i, addr_i          request, op select (1=erase), flash byte address
//  writeData_i, byteSelect_i             little-endian program word and its byte enables
//  busy_o, done_o                        CPU stall, one-cycle completion pulse
//  clk_o, cs_n_o, di_o, do_i             SPI mode 0 SCK, chip select, MOSI, MISO
module flash_prog_ctrl #(
  parameter int CLK_DIV = 1,
  parameter int CS_HIGH_CYC = 4
) (
  input  logic        clkMain,
  input  logic        rst,
  input  logic        devEnable_i,
  input  logic        erase_i,
  input  logic [23:0] addr_i,
  input  logic [31:0] writeData_i,
  input  logic [3:0]  byteSelect_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        clk_o,
  output logic        cs_n_o,
  output logic        di_o,
  input  logic        do_i
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_HIGH_CYC + 1);
  typedef enum logic [2:0] {IDLE, WREN, GAP1, CMD, GAP2, POLL, DONE} state_t;
  state_t state, state_n;
  logic ers_r;
  logic [23:0] addr_r;
  logic [31:0] dat_r;
  logic [3:0] bs_r;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic half, tail, cs_n_r, sck_r;
  logic [2:0] bit_cnt, idx, ni, last_idx;
  logic [7:0] sh, rx, rx_n, nb, fb;
  logic [1:0] lo, hi, k;
  logic shifting, entering, half_end, xfer_end, gap_end, last;
  always_comb begin
    shifting = state == WREN || state == CMD || state == POLL;
    entering = state_n != state && (state_n == WREN || state_n == CMD || state_n == POLL);
    half_end = cnt == CW'(CLK_DIV - 1);
    xfer_end = shifting && tail && half_end;
    gap_end = gap_cnt == GW'(CS_HIGH_CYC - 1);
    rx_n = {rx[6:0], do_i};
    lo = bs_r[0] ? 2'd0 : bs_r[1] ? 2'd1 : bs_r[2] ? 2'd2 : 2'd3;
    hi = bs_r[3] ? 2'd3 : bs_r[2] ? 2'd2 : bs_r[1] ? 2'd1 : 2'd0;
    last_idx = ers_r ? 3'd3 : 3'd4 + {1'b0, hi - lo};
    ni = idx + 3'd1;
    k = lo + ni[1:0];
    nb = state == POLL ? 8'h00 :
         ni == 3'd1 ? addr_r[23:16] :
         ni == 3'd2 ? addr_r[15:8] :
         ni == 3'd3 ? (ers_r ? addr_r[7:0] : {addr_r[7:2], lo}) :
         bs_r[k] ? dat_r[{k, 3'b000} +: 8] : 8'hFF;
    last = state == WREN || (state == CMD ? idx == last_idx : idx != 3'd0 && !rx_n[0]);
    fb = state_n == WREN ? 8'h06 : state_n == CMD ? (ers_r ? 8'h20 : 8'h02) : 8'h05;
  end
  always_ff @(posedge clkMain) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (devEnable_i) state_n = (erase_i || |byteSelect_i) ? WREN : DONE;
      WREN: if (xfer_end) state_n = GAP1;
      GAP1: if (gap_end) state_n = CMD;
      CMD:  if (xfer_end) state_n = GAP2;
      GAP2: if (gap_end) state_n = POLL;
      POLL: if (xfer_end) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy_o = (state != IDLE && state != DONE) || (state == IDLE && devEnable_i && |byteSelect_i && !rst);
    done_o = state == DONE;
    clk_o = sck_r;
    cs_n_o = cs_n_r;
    di_o = sh[7];
  end
  always_ff @(posedge clkMain) begin
    if (rst) begin
      cs_n_r <= 1'b1;
      sck_r <= 1'b0;
      sh <= 8'h00;
      rx <= 8'h00;
      half <= 1'b0;
      tail <= 1'b0;
      cnt <= '0;
      bit_cnt <= 3'd0;
      idx <= 3'd0;
    end else if (entering) begin
      cs_n_r <= 1'b0;
      sck_r <= 1'b0;
      sh <= fb;
      half <= 1'b0;
      tail <= 1'b0;
      cnt <= '0;
      bit_cnt <= 3'd7;
      idx <= 3'd0;
    end else if (shifting && half_end) begin
      cnt <= '0;
      if (tail) cs_n_r <= 1'b1;
      else if (!half) begin
        sck_r <= 1'b1;
        half <= 1'b1;
      end else begin
        sck_r <= 1'b0;
        half <= 1'b0;
        rx <= rx_n;
        bit_cnt <= bit_cnt - 3'd1;
        sh <= bit_cnt != 3'd0 ? {sh[6:0], 1'b0} : last ? 8'h00 : nb;
        tail <= bit_cnt == 3'd0 && last;
        idx <= bit_cnt != 3'd0 ? idx : state == POLL ? 3'd1 : ni;
      end
    end else if (shifting) cnt <= cnt + 1'b1;
  end
  always_ff @(posedge clkMain) begin
    if (state == IDLE && devEnable_i) begin
      ers_r <= erase_i;
      addr_r <= addr_i;
      dat_r <= writeData_i;
      bs_r <= byteSelect_i;
    end
    gap_cnt <= (state == GAP1 || state == GAP2) && !gap_end ? gap_cnt + 1'b1 : '0;
  end
endmodule

// File: tb/tb_flash_prog_ctrl.sv
// tb_flash_prog_ctrl: scoreboard bench for flash_prog_ctrl with a behavioural SPI flash model
module tb_flash_prog_ctrl;
  localparam int DIV = 2;
  localparam int CSH = 4;
  logic clkMain = 1'b0, rst = 1'b1, devEnable_i = 1'b0, erase_i = 1'b0, do_i = 1'b0;
  logic [23:0] addr_i = '0;
  logic [31:0] writeData_i = '0;
  logic [3:0] byteSelect_i = '0;
  logic busy_o, done_o, clk_o, cs_n_o, di_o;
  flash_prog_ctrl #(.CLK_DIV(DIV), .CS_HIGH_CYC(CSH)) dut (
    .clkMain(clkMain), .rst(rst), .devEnable_i(devEnable_i), .erase_i(erase_i),
    .addr_i(addr_i), .writeData_i(writeData_i), .byteSelect_i(byteSelect_i),
    .busy_o(busy_o), .done_o(done_o), .clk_o(clk_o), .cs_n_o(cs_n_o), .di_o(di_o), .do_i(do_i)
  );
  always #5 clkMain = ~clkMain;
  typedef struct packed {logic [7:0] len; logic [63:0] b;} frame_t;
  frame_t exp_q[$];
  logic [7:0] stat_q[$];
  int pending_done = 0, n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic stat_bit(input int n);
    int j;
    if (n < 8) return 1'b0;
    j = (n - 8) / 8;
    if (j >= stat_q.size()) return 1'b0;
    return stat_q[j][7 - ((n - 8) % 8)];
  endfunction
  task automatic set_stat(input int nbusy);
    stat_q.delete();
    for (int i = 0; i < nbusy; i++) stat_q.push_back(8'($urandom) | 8'h01);
    stat_q.push_back(8'($urandom) & 8'hFE);
  endtask
  task automatic expect_op(input logic er, input logic [23:0] a, input logic [31:0] d, input logic [3:0] bs);
    logic [63:0] b;
    int len, lo, hi;
    pending_done++;
    if (!er && bs == 4'd0) return;
    exp_q.push_back('{8'd1, 64'h06});
    b = '0;
    b[7:0] = er ? 8'h20 : 8'h02;
    b[15:8] = a[23:16];
    b[23:16] = a[15:8];
    len = 4;
    if (er) b[31:24] = a[7:0];
    else begin
      lo = -1;
      hi = 0;
      for (int i = 0; i < 4; i++) if (bs[i]) begin
        if (lo < 0) lo = i;
        hi = i;
      end
      b[31:24] = {a[7:2], 2'(lo)};
      for (int i = lo; i <= hi; i++) begin
        b[8*len +: 8] = bs[i] ? d[8*i +: 8] : 8'hFF;
        len++;
      end
    end
    exp_q.push_back('{8'(len), b});
    exp_q.push_back('{8'(1 + stat_q.size()), 64'h05});
  endtask
  task automatic run_op(input logic er, input logic [23:0] a, input logic [31:0] d, input logic [3:0] bs);
    bit ok;
    expect_op(er, a, d, bs);
    erase_i = er;
    addr_i = a;
    writeData_i = d;
    byteSelect_i = bs;
    devEnable_i = 1'b1;
    #1;
    check("busy_request_cycle", busy_o, bs != 4'd0);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clkMain);
      #1;
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    devEnable_i = 1'b0;
    check("done_within_budget", ok, 1'b1);
    @(posedge clkMain);
    #1;
  endtask
  bit in_frame = 1'b0, prev_cs = 1'b1, prev_sck = 1'b0, gap_busy = 1'b0;
  int nbits = 0, dur = 0, gap_len = 0;
  logic [63:0] cur = '0;
  frame_t f;
  always @(negedge clkMain) begin
    if (rst) in_frame = 1'b0;
    else begin
      if (prev_cs && !cs_n_o) begin
        if (gap_busy) check("cs_high_gap", gap_len, CSH);
        in_frame = 1'b1;
        nbits = 0;
        dur = 0;
        cur = '0;
        do_i = 1'b0;
      end
      if (!cs_n_o && in_frame) begin
        dur++;
        if (clk_o && !prev_sck) begin
          if (nbits < 64) cur[8*(nbits/8) + 7 - (nbits%8)] = di_o;
          nbits++;
        end
        if (!clk_o && prev_sck) do_i = stat_bit(nbits);
      end
      if (!prev_cs && cs_n_o && in_frame) begin
        in_frame = 1'b0;
        if (exp_q.size() == 0) check("unexpected_frame_bits", nbits, 0);
        else begin
          f = exp_q.pop_front();
          check("frame_bits", nbits, 8 * int'(f.len));
          check("frame_bytes", cur, f.b);
          check("frame_cs_low_cycles", dur, 16 * DIV * int'(f.len) + DIV);
        end
      end
      if (cs_n_o) begin
        if (!prev_cs) begin
          gap_len = 0;
          gap_busy = 1'b1;
        end
        gap_len++;
        gap_busy = gap_busy && busy_o;
      end else gap_busy = 1'b0;
      if (done_o) begin
        check("done_expected", pending_done > 0, 1'b1);
        check("busy_low_at_done", busy_o, 1'b0);
        if (pending_done > 0) pending_done--;
      end
    end
    prev_cs = cs_n_o;
    prev_sck = clk_o;
  end
  initial begin
    repeat (3) @(posedge clkMain);
    #1;
    check("reset_outputs", {cs_n_o, clk_o, di_o, busy_o, done_o}, 5'b10000);
    rst = 1'b0;
    @(posedge clkMain);
    #1;
    check("idle_outputs", {cs_n_o, clk_o, di_o, busy_o, done_o}, 5'b10000);
    stat_q = '{8'h03, 8'h03, 8'h00};
    run_op(1'b0, 24'h000100, 32'h11223344, 4'b1111);
    set_stat(1);
    run_op(1'b0, 24'h000100, 32'h11223344, 4'b0100);
    set_stat(0);
    run_op(1'b0, 24'h000100, 32'h11223344, 4'b1001);
    stat_q = '{8'h00};
    run_op(1'b1, 24'h012345, 32'h0, 4'b1111);
    run_op(1'b0, 24'h000200, 32'hCAFEF00D, 4'b0000);
    check("bs0_no_spi_frames", exp_q.size(), 0);
    stat_q = '{8'h00};
    exp_q.push_back('{8'd1, 64'h06});
    erase_i = 1'b0;
    addr_i = 24'h000100;
    writeData_i = 32'h11223344;
    byteSelect_i = 4'b1111;
    devEnable_i = 1'b1;
    repeat (60) @(posedge clkMain);
    #1;
    check("mid_cmd_cs_low", cs_n_o, 1'b0);
    rst = 1'b1;
    @(posedge clkMain);
    #1;
    rst = 1'b0;
    devEnable_i = 1'b0;
    #1;
    check("after_rst_outputs", {cs_n_o, clk_o, busy_o, done_o}, 4'b1000);
    check("wren_before_rst", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clkMain);
    #1;
    set_stat(2);
    run_op(1'b0, 24'h000104, 32'hA5A55A5A, 4'b0110);
    for (int t = 0; t < 20; t++) begin
      set_stat(int'($urandom_range(0, 2)));
      run_op(($urandom % 4) == 0, 24'($urandom), $urandom, 4'($urandom));
    end
    repeat (5) @(posedge clkMain);
    #1;
    check("all_frames_seen", exp_q.size(), 0);
    check("all_done_seen", pending_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
